nibble_serial_adder: RTL

//  - Sequential front/back end for the 4-bit ripple adder (adder_4bit).
//  - Accepts WIDTH-bit operands over a valid/ready handshake and feeds them to one adder_4bit instance, one nibble per clock, LSB first.
//  - Chains the carry through a register, collects the sum nibbles and presents the WIDTH-bit result over a valid/ready handshake.
//  - Result: WIDTH-bit add from a single 4-bit adder at 4-bit critical-path timing.

---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_4bit.sv | 23 ++
 rtl/nibble_serial_adder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encodings and
// the nibble width used to slice operands.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : adder_pkg

// File: rtl/adder_4bit.sv
// 4-bit ripple-carry adder; the single combinational datapath reused every
// cycle by the nibble-serial front end.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    // Ripple the carry bit by bit so the critical path is one 4-bit chain.
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule : adder_4bit

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder built from one adder_4bit, one nibble per clock, LSB first.
// Operands enter on a valid/ready handshake; the result leaves on another.
// Optional feature: define NIBBLE_SERIAL_OVF_EN to add a registered signed
// overflow flag (out_ovf) presented alongside out_sum.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef NIBBLE_SERIAL_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       nib_idx_q, nib_idx_d;
    logic                   carry_q, carry_d;
    logic [WIDTH-1:0]       op_a_q, op_a_d;
    logic [WIDTH-1:0]       op_b_q, op_b_d;
    logic [WIDTH-1:0]       sum_q, sum_d;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic                   ovf_q, ovf_d;
`endif

    logic [NIBBLE_W-1:0]    nib_a, nib_b, nib_s;
    logic                   nib_cout;

    assign nib_a = op_a_q[NIBBLE_W*nib_idx_q +: NIBBLE_W];
    assign nib_b = op_b_q[NIBBLE_W*nib_idx_q +: NIBBLE_W];

    adder_4bit u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_cout)
    );

    // Next-state and datapath updates: capture on accept, one nibble per
    // cycle in ADD, hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d   = state_q;
        nib_idx_d = nib_idx_q;
        carry_d   = carry_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sum_d     = sum_q;
`ifdef NIBBLE_SERIAL_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_a_d    = in_a;
                    op_b_d    = in_b;
                    carry_d   = in_cin;
                    nib_idx_d = '0;
                    state_d   = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_d[NIBBLE_W*nib_idx_q +: NIBBLE_W] = nib_s;
                carry_d = nib_cout;
                if (nib_idx_q == LAST_IDX) begin
                    // Index stays at the last nibble; it is reloaded on accept.
                    state_d = ST_DONE;
`ifdef NIBBLE_SERIAL_OVF_EN
                    ovf_d = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &
                            (nib_s[NIBBLE_W-1] != op_a_q[WIDTH-1]);
`endif
                end else begin
                    nib_idx_d = nib_idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            nib_idx_q <= '0;
            carry_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sum_q     <= '0;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            nib_idx_q <= nib_idx_d;
            carry_q   <= carry_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sum_q     <= sum_d;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
`ifdef NIBBLE_SERIAL_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule : nibble_serial_adder
